// File: rtl/stall_mem_responder.sv
// Multi-cycle word-addressed data memory for a stalling pipeline memory stage.
// One access in flight at a time; Stall while pending, one-cycle Done with read data.
module stall_mem_responder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Stall,
    output logic              Done,
    output logic              err
);

    localparam int unsigned WORDS    = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    wr_q;
    logic [DATA_W-1:0]       dout_q;
    logic [DATA_W-1:0]       mem_q [WORDS];

    logic                    legal;
    logic                    accept;
    logic [DEPTH_LOG2-1:0]   idx_in;
    logic                    unused_addr_hi;

    // Upper address bits alias onto the array without raising an error.
    assign idx_in         = Addr[DEPTH_LOG2:1];
    assign unused_addr_hi = ^Addr[15:DEPTH_LOG2+1];

    assign legal  = (Rd ^ Wr) & ~Addr[0];
    assign accept = (state_q != BUSY) & legal;

    assign Stall   = (state_q == BUSY) | (accept & (LATENCY > 1));
    assign err     = (Rd | Wr) & (state_q != BUSY) & ~legal;
    assign Done    = (state_q == DONE);
    assign DataOut = dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= DONE;
                        if (wr_q) begin
                            mem_q[idx_q] <= wdata_q;
                        end else begin
                            dout_q <= mem_q[idx_q];
                        end
                    end
                end
                default: begin
                    dout_q <= '0;
                    if (accept) begin
                        idx_q   <= idx_in;
                        wdata_q <= DataIn;
                        wr_q    <= Wr;
                        if (LATENCY == 1) begin
                            // Single-cycle latency completes at the acceptance edge itself.
                            state_q <= DONE;
                            if (Wr) begin
                                mem_q[idx_in] <= DataIn;
                            end else begin
                                dout_q <= mem_q[idx_in];
                            end
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_W'(CNT_LOAD);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
